access_door_ctrl: RTL and testbench
===================================

Name: access_door_ctrl

Overview:
- Parametrised door access controller; next generation of the single-door ID checker.
- Compares a presented badge ID against a run-time programmable table of authorised IDs, and holds the door open for a fixed number of cycles.
- Adds what the first generation lacked: ID-entry timeout, failed-attempt counting with lockout, and grant/deny/timeout status pulses.
- Sits between the badge-reader front end and the door actuator/status LEDs.

Parameters:
- ID_W, 4: width of the identity number in bits.
- NUM_IDS, 4: number of authorised-ID table entries (1..16).
- OPEN_CYCLES, 5: cycles `pass` stays high per grant (>=1).
- WAIT_CYCLES, 16: cycles allowed in CHECK without a valid ID before timeout (>=1).
- MAX_FAILS, 3: consecutive denials that trigger lockout (>=1).
- LOCK_CYCLES, 32: cycles spent in LOCKOUT (>=1).

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- tx, input, 1: access request (badge presented); sampled in IDLE only.
- id_valid, input, 1: identityNumber is valid this cycle; sampled in CHECK only.
- identityNumber, input, ID_W: presented ID.
- prog_we, input, 1: table write enable.
- prog_addr, input, $clog2(NUM_IDS) (min 1): table entry index.
- prog_id, input, ID_W: ID to store.
- prog_en_bit, input, 1: entry valid bit to store.
- pass, output, 1: door unlock.
- denied, output, 1: one-cycle pulse on a failed compare.
- timeout, output, 1: one-cycle pulse on CHECK timeout.
- locked, output, 1: high while in LOCKOUT.
- grant_idx, output, $clog2(NUM_IDS) (min 1): index of the matching entry; held through OPEN.
- fail_cnt, output, $clog2(MAX_FAILS+1) (min 1): current consecutive-failure count.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; all outputs 0; counters 0.
  - Table entry i gets ID i+1 (truncated to ID_W) with valid=1. With default parameters, IDs 1..4 are authorised.
  - Reset has priority over everything, including mid-OPEN and mid-LOCKOUT; pass drops the edge after rst is sampled.
- All outputs are registered and update on posedge clk. No negedge logic.
- IDLE:
  - tx=1 -> CHECK at the next edge; wait counter cleared.
  - tx is ignored in every other state.
- CHECK: wait counter increments each cycle id_valid=0.
  - id_valid=1 and identityNumber equals a valid entry -> OPEN.
    - On that edge: pass<=1, grant_idx<=lowest matching index, fail_cnt<=0.
  - id_valid=1 and no match -> denied<=1 for one cycle; fail_cnt increments.
    - If the new count equals MAX_FAILS -> LOCKOUT; locked<=1 on that edge.
    - Otherwise stay in CHECK with the wait counter cleared.
  - Wait counter reaches WAIT_CYCLES with no id_valid -> IDLE; timeout<=1 for one cycle; fail_cnt unchanged.
  - id_valid takes priority over timeout on the same cycle.
- OPEN:
  - pass=1 for exactly OPEN_CYCLES clock cycles, then IDLE with pass=0.
  - id_valid and tx are ignored.
- LOCKOUT:
  - locked=1 for exactly LOCK_CYCLES cycles, then IDLE with locked=0 and fail_cnt=0.
  - tx and id_valid are ignored.
- Table programming:
  - Writes are accepted in any state; the written entry is visible from the next cycle.
  - A compare in the same cycle as a write uses the pre-write contents.
  - prog_addr >= NUM_IDS is ignored.
  - Entries with valid=0 never match, even if their stored ID equals identityNumber.
- Duplicate IDs in the table are legal; the lowest index wins.
- fail_cnt persists across timeouts and IDLE; it clears only on a grant, at the end of LOCKOUT, or on reset.

Test Plan:
1. Reset, tx=1 for one cycle, then id_valid=1 with identityNumber=2 -> pass rises on the id edge, stays high exactly 5 cycles, grant_idx=1, fail_cnt=0; then back to IDLE.
2. tx=1, then identityNumber=8 with id_valid=1 on three separate cycles -> denied pulses three times, fail_cnt counts 1, 2, 3; locked=1 for 32 cycles. A tx during the lockout has no effect. Afterwards locked=0 and fail_cnt=0.
3. tx=1, then no id_valid for 16 cycles -> timeout pulses once, state returns to IDLE, pass stays 0. A prior fail_cnt=1 is preserved.
4. Program entry 3 with prog_id=9 and prog_en_bit=1, then present ID 9 -> grant with grant_idx=3. Program entry 0 with valid=0, then present ID 1 -> denied.
5. Assert rst on the 3rd cycle of OPEN -> pass=0 the next cycle; table restored to IDs 1..4.
6. Write entry 2 to ID 7 on the same cycle ID 7 is presented in CHECK -> denied, because the old table is used. Present ID 7 again next cycle -> grant.

Source files
------------

// File: rtl/access_door_ctrl.sv
// Door access controller: checks a presented badge ID against a programmable table and
// sequences unlock, entry timeout, failed-attempt counting and lockout.
module access_door_ctrl #(
    parameter int unsigned ID_W        = 4,
    parameter int unsigned NUM_IDS     = 4,
    parameter int unsigned OPEN_CYCLES = 5,
    parameter int unsigned WAIT_CYCLES = 16,
    parameter int unsigned MAX_FAILS   = 3,
    parameter int unsigned LOCK_CYCLES = 32,
    localparam int unsigned AW = (NUM_IDS > 1) ? $clog2(NUM_IDS) : 1,
    localparam int unsigned FW = (MAX_FAILS > 1) ? $clog2(MAX_FAILS + 1) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tx,
    input  logic            id_valid,
    input  logic [ID_W-1:0] identityNumber,
    input  logic            prog_we,
    input  logic [AW-1:0]   prog_addr,
    input  logic [ID_W-1:0] prog_id,
    input  logic            prog_en_bit,
    output logic            pass,
    output logic            denied,
    output logic            timeout,
    output logic            locked,
    output logic [AW-1:0]   grant_idx,
    output logic [FW-1:0]   fail_cnt
);

    localparam int unsigned CNT_TOP0 = (OPEN_CYCLES > WAIT_CYCLES) ? OPEN_CYCLES : WAIT_CYCLES;
    localparam int unsigned CNT_TOP  = (LOCK_CYCLES > CNT_TOP0) ? LOCK_CYCLES : CNT_TOP0;
    localparam int unsigned CW       = $clog2(CNT_TOP + 1);

    typedef enum logic [1:0] {StIdle, StCheck, StOpen, StLockout} state_e;

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [ID_W-1:0]   tab_id_q [NUM_IDS];
    logic [NUM_IDS-1:0] tab_en_q;

    logic              hit;
    logic [AW-1:0]     hit_idx;

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = int'(NUM_IDS) - 1; i >= 0; i--) begin
            if (tab_en_q[i] && (tab_id_q[i] == identityNumber)) begin
                hit     = 1'b1;
                hit_idx = AW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            pass      <= 1'b0;
            denied    <= 1'b0;
            timeout   <= 1'b0;
            locked    <= 1'b0;
            grant_idx <= '0;
            fail_cnt  <= '0;
            for (int i = 0; i < int'(NUM_IDS); i++) begin
                tab_id_q[i] <= ID_W'(i + 1);
                tab_en_q[i] <= 1'b1;
            end
        end else begin
            denied  <= 1'b0;
            timeout <= 1'b0;

            // The compare above reads the old contents, so a same-cycle write is seen next cycle.
            if (prog_we && (32'(prog_addr) < NUM_IDS)) begin
                tab_id_q[prog_addr] <= prog_id;
                tab_en_q[prog_addr] <= prog_en_bit;
            end

            case (state_q)
                StIdle: begin
                    if (tx) begin
                        state_q <= StCheck;
                        cnt_q   <= '0;
                    end
                end

                StCheck: begin
                    if (id_valid) begin
                        cnt_q <= '0;
                        if (hit) begin
                            state_q   <= StOpen;
                            pass      <= 1'b1;
                            grant_idx <= hit_idx;
                            fail_cnt  <= '0;
                        end else begin
                            denied   <= 1'b1;
                            fail_cnt <= fail_cnt + 1'b1;
                            if (fail_cnt == FW'(MAX_FAILS - 1)) begin
                                state_q <= StLockout;
                                locked  <= 1'b1;
                            end
                        end
                    end else if (cnt_q == CW'(WAIT_CYCLES - 1)) begin
                        state_q <= StIdle;
                        timeout <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StOpen: begin
                    if (cnt_q == CW'(OPEN_CYCLES - 1)) begin
                        state_q <= StIdle;
                        pass    <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StLockout: begin
                    if (cnt_q == CW'(LOCK_CYCLES - 1)) begin
                        state_q  <= StIdle;
                        locked   <= 1'b0;
                        fail_cnt <= '0;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_access_door_ctrl.sv
// Directed self-checking bench for access_door_ctrl at default parameters.
module tb_access_door_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx;
    logic       id_valid;
    logic [3:0] identityNumber;
    logic       prog_we;
    logic [1:0] prog_addr;
    logic [3:0] prog_id;
    logic       prog_en_bit;
    logic       pass;
    logic       denied;
    logic       timeout;
    logic       locked;
    logic [1:0] grant_idx;
    logic [1:0] fail_cnt;

    int checks = 0;
    int errors = 0;

    access_door_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .tx             (tx),
        .id_valid       (id_valid),
        .identityNumber (identityNumber),
        .prog_we        (prog_we),
        .prog_addr      (prog_addr),
        .prog_id        (prog_id),
        .prog_en_bit    (prog_en_bit),
        .pass           (pass),
        .denied         (denied),
        .timeout        (timeout),
        .locked         (locked),
        .grant_idx      (grant_idx),
        .fail_cnt       (fail_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic present(input logic [3:0] id);
        id_valid       = 1'b1;
        identityNumber = id;
        step();
        id_valid       = 1'b0;
    endtask

    task automatic request();
        tx = 1'b1;
        step();
        tx = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b want 0", pass); end
        checks++; if (denied !== 1'b0) begin errors++; $display("FAIL reset_denied: got %b want 0", denied); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
        checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL reset_grant_idx: got %0d want 0", grant_idx); end
        checks++; if (fail_cnt !== 2'd0) begin errors++; $display("FAIL reset_fail_cnt: got %0d want 0", fail_cnt); end
    endtask

    task automatic test_grant();
        request();
        present(4'd2);
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL grant_pass_rise: got %b want 1", pass); end
        checks++; if (grant_idx !== 2'd1) begin errors++; $display("FAIL grant_idx: got %0d want 1", grant_idx); end
        checks++; if (fail_cnt !== 2'd0) begin errors++; $display("FAIL grant_fail_cnt: got %0d want 0", fail_cnt); end
        for (int k = 2; k <= 5; k++) begin
            if (k == 3) tx = 1'b1;
            step();
            tx = 1'b0;
            checks++; if (pass !== 1'b1) begin errors++; $display("FAIL grant_pass_hold%0d: got %b want 1", k, pass); end
            checks++; if (grant_idx !== 2'd1) begin errors++; $display("FAIL grant_idx_hold%0d: got %0d want 1", k, grant_idx); end
        end
        step();
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL grant_pass_fall: got %b want 0", pass); end
        // Back in IDLE: an id without tx must not open.
        present(4'd2);
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL grant_idle_noreq: got %b want 0", pass); end
    endtask

    task automatic test_lockout();
        request();
        for (int f = 1; f <= 3; f++) begin
            present(4'd8);
            checks++; if (denied !== 1'b1) begin errors++; $display("FAIL lock_denied%0d: got %b want 1", f, denied); end
            checks++; if (fail_cnt !== 2'(f)) begin errors++; $display("FAIL lock_fail_cnt%0d: got %0d want %0d", f, fail_cnt, f); end
            checks++; if (locked !== (f == 3)) begin errors++; $display("FAIL lock_locked%0d: got %b want %b", f, locked, f == 3); end
            step();
            checks++; if (denied !== 1'b0) begin errors++; $display("FAIL lock_denied_pulse%0d: got %b want 0", f, denied); end
        end
        tx = 1'b1;
        step();
        tx = 1'b0;
        for (int k = 3; k <= 31; k++) begin
            step();
            checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_hold%0d: got %b want 1", k, locked); end
        end
        step();
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_release: got %b want 0", locked); end
        checks++; if (fail_cnt !== 2'd0) begin errors++; $display("FAIL lock_fail_clear: got %0d want 0", fail_cnt); end
        present(4'd2);
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL lock_tx_ignored: got %b want 0", pass); end
    endtask

    task automatic test_timeout();
        request();
        present(4'd8);
        checks++; if (fail_cnt !== 2'd1) begin errors++; $display("FAIL to_prior_fail: got %0d want 1", fail_cnt); end
        for (int k = 1; k <= 15; k++) begin
            step();
            checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_early%0d: got %b want 0", k, timeout); end
        end
        step();
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b want 1", timeout); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL to_pass: got %b want 0", pass); end
        checks++; if (fail_cnt !== 2'd1) begin errors++; $display("FAIL to_fail_kept: got %0d want 1", fail_cnt); end
        step();
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_one_shot: got %b want 0", timeout); end
        present(4'd2);
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL to_back_idle: got %b want 0", pass); end
        checks++; if (fail_cnt !== 2'd1) begin errors++; $display("FAIL to_fail_idle: got %0d want 1", fail_cnt); end
    endtask

    task automatic test_program();
        prog_we = 1'b1; prog_addr = 2'd3; prog_id = 4'd9; prog_en_bit = 1'b1;
        step();
        prog_we = 1'b0;
        request();
        present(4'd9);
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL prog_grant9: got %b want 1", pass); end
        checks++; if (grant_idx !== 2'd3) begin errors++; $display("FAIL prog_idx9: got %0d want 3", grant_idx); end
        checks++; if (fail_cnt !== 2'd0) begin errors++; $display("FAIL prog_fail_clear: got %0d want 0", fail_cnt); end
        for (int k = 0; k < 5; k++) step();
        prog_we = 1'b1; prog_addr = 2'd0; prog_id = 4'd1; prog_en_bit = 1'b0;
        step();
        prog_we = 1'b0;
        request();
        present(4'd1);
        checks++; if (denied !== 1'b1) begin errors++; $display("FAIL prog_disabled_denied: got %b want 1", denied); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL prog_disabled_pass: got %b want 0", pass); end
        checks++; if (fail_cnt !== 2'd1) begin errors++; $display("FAIL prog_disabled_cnt: got %0d want 1", fail_cnt); end
    endtask

    task automatic test_reset_in_open();
        // Still in CHECK from the previous denial.
        present(4'd2);
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL rio_grant: got %b want 1", pass); end
        step();
        step();
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL rio_third_cycle: got %b want 1", pass); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL rio_pass_drop: got %b want 0", pass); end
        checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL rio_idx_clear: got %0d want 0", grant_idx); end
        request();
        present(4'd1);
        checks++; if (grant_idx !== 2'd0 || pass !== 1'b1) begin errors++; $display("FAIL rio_table0: got pass=%b idx=%0d want pass=1 idx=0", pass, grant_idx); end
        for (int k = 0; k < 5; k++) step();
        request();
        present(4'd4);
        checks++; if (grant_idx !== 2'd3 || pass !== 1'b1) begin errors++; $display("FAIL rio_table3: got pass=%b idx=%0d want pass=1 idx=3", pass, grant_idx); end
        for (int k = 0; k < 5; k++) step();
    endtask

    task automatic test_write_during_compare();
        apply_reset();
        request();
        prog_we = 1'b1; prog_addr = 2'd2; prog_id = 4'd7; prog_en_bit = 1'b1;
        present(4'd7);
        prog_we = 1'b0;
        checks++; if (denied !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL wdc_old_table: got denied=%b pass=%b want denied=1 pass=0", denied, pass); end
        present(4'd7);
        checks++; if (pass !== 1'b1 || grant_idx !== 2'd2) begin errors++; $display("FAIL wdc_new_table: got pass=%b idx=%0d want pass=1 idx=2", pass, grant_idx); end
        for (int k = 0; k < 5; k++) step();
        // Duplicate ID: entry 3 also holds 2, entry 1 must win.
        prog_we = 1'b1; prog_addr = 2'd3; prog_id = 4'd2; prog_en_bit = 1'b1;
        step();
        prog_we = 1'b0;
        request();
        present(4'd2);
        checks++; if (pass !== 1'b1 || grant_idx !== 2'd1) begin errors++; $display("FAIL dup_lowest: got pass=%b idx=%0d want pass=1 idx=1", pass, grant_idx); end
        for (int k = 0; k < 5; k++) step();
    endtask

    initial begin
        rst = 1'b1; tx = 1'b0; id_valid = 1'b0; identityNumber = '0;
        prog_we = 1'b0; prog_addr = '0; prog_id = '0; prog_en_bit = 1'b0;
        #1;
        test_reset();
        test_grant();
        test_lockout();
        test_timeout();
        test_program();
        test_reset_in_open();
        test_write_during_compare();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
